keystream_xor: RTL and testbench

//   Downstream consumer of the chaotic-value extractor. Takes extractor triples (ex1..ex3,

---
 rtl/keystream_xor.sv | 155 +++++++++++++++
 tb/tb_keystream_xor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keystream_xor.sv
// ---------------------------------------------------------------------------
// keystream_xor
//   Buffers extractor triples (ex1..ex3) in a small FIFO and serialises each
//   triple into three key bytes: ex1, ex2, then ex3, each taken mod 256.
//   Every accepted pixel byte is combined with the current key byte and a
//   chaining register:
//       r = pix_data ^ key ^ chain
//   The chain always follows the ciphertext. In encrypt mode that is the
//   result r. In decrypt mode it is the incoming byte. This lets one datapath
//   serve both directions.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               1-cycle pulse: restart chaining and the key byte index
//   dec                 0 = encrypt, 1 = decrypt (change only while idle)
//   ex_valid/ex_ready   triple push handshake; ex1..ex3 carry the key values
//   pix_valid/pix_ready input byte handshake; pix_data is the input byte
//   out_valid/out_ready output byte handshake; out_data is the output byte
//   key_level           number of triples currently held in the FIFO
// ---------------------------------------------------------------------------
module keystream_xor #(
    parameter int         DEPTH = 4,
    parameter logic [7:0] IV    = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       dec,
    input  logic                       ex_valid,
    input  logic [22:0]                ex1,
    input  logic [22:0]                ex2,
    input  logic [22:0]                ex3,
    output logic                       ex_ready,
    input  logic                       pix_valid,
    input  logic [7:0]                 pix_data,
    output logic                       pix_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     key_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Triple storage. It has no reset: the pointers and count alone decide
    // which entries are live.
    logic [23:0]   mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [7:0]    chain_reg;
    logic [1:0]    byte_idx_reg;
    logic          out_valid_reg;
    logic [7:0]    out_data_reg;

    logic [23:0]   head;
    logic [7:0]    key_byte;
    logic [7:0]    result;
    logic          push;
    logic          pop;
    logic          xfer;
    logic [CW-1:0] count_next;
    logic [1:0]    byte_idx_next;

    // Only the low byte of each extractor value is used.
    logic unused_ex_bits;
    assign unused_ex_bits = ^{ex1[22:8], ex2[22:8], ex3[22:8]};

    assign ex_ready  = (count_reg != CW'(DEPTH));
    assign pix_ready = (count_reg != '0) && (!out_valid_reg || out_ready) && !start;

    assign push = ex_valid && ex_ready;
    assign xfer = pix_valid && pix_ready;

    // The head triple is popped once its third byte is used. It is also
    // popped when a start abandons it part-way through.
    assign pop = (xfer && (byte_idx_reg == 2'd2)) || (start && (byte_idx_reg != 2'd0));

    assign count_next = count_reg + CW'(push) - CW'(pop);

    // Head is read combinationally. The FIFO is only a few entries deep, so
    // this maps to distributed storage, and the key byte is ready in the
    // same cycle as the pixel.
    assign head = mem_reg[rd_ptr_reg];

    always_comb begin
        key_byte = head[7:0];
        case (byte_idx_reg)
            2'd1:    key_byte = head[15:8];
            2'd2:    key_byte = head[23:16];
            default: key_byte = head[7:0];
        endcase
    end

    assign result = pix_data ^ key_byte ^ chain_reg;

    always_comb begin
        byte_idx_next = byte_idx_reg;
        if (start) begin
            byte_idx_next = 2'd0;
        end else if (xfer) begin
            byte_idx_next = (byte_idx_reg == 2'd2) ? 2'd0 : byte_idx_reg + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {ex3[7:0], ex2[7:0], ex1[7:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            chain_reg     <= IV;
            byte_idx_reg  <= 2'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg    <= count_next;
            byte_idx_reg <= byte_idx_next;

            if (start) begin
                chain_reg <= IV;
            end else if (xfer) begin
                chain_reg <= dec ? pix_data : result;
            end

            // A pending output byte is held until it is taken. A start pulse
            // does not affect it.
            if (xfer) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= result;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign key_level = count_reg;

endmodule

// File: tb/tb_keystream_xor.sv
// ---------------------------------------------------------------------------
// tb_keystream_xor
//   Directed bench for keystream_xor. The stimulus process pushes the
//   hand-computed expected byte into a scoreboard queue whenever a pixel is
//   accepted. A separate monitor pops and compares whenever an output byte
//   is handed over.
// ---------------------------------------------------------------------------
module tb_keystream_xor;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dec = 1'b0;
    logic        ex_valid = 1'b0;
    logic [22:0] ex1 = '0;
    logic [22:0] ex2 = '0;
    logic [22:0] ex3 = '0;
    logic        ex_ready;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
    logic [$clog2(DEPTH):0] key_level;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    keystream_xor #(.DEPTH(DEPTH), .IV(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .dec(dec),
        .ex_valid(ex_valid), .ex1(ex1), .ex2(ex2), .ex3(ex3), .ex_ready(ex_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .key_level(key_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: one comparison per delivered output byte.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_byte: got %0h expected nothing (scoreboard empty)", out_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_byte: got %0h expected %0h", out_data, e);
                end else begin
                    $display("ok   out_byte: %0h", out_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int b, input int c);
        ex_valid = 1'b1;
        ex1 = 23'(a);
        ex2 = 23'(b);
        ex3 = 23'(c);
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers one pixel and waits (bounded) until it is accepted. On
    // acceptance it queues the expected output and checks for 1-cycle latency.
    task automatic send_pix(input logic [7:0] d, input logic [7:0] exp, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        pix_valid = 1'b1;
        pix_data = d;
        while (!ok) begin
            @(negedge clk);
            if (pix_ready) begin
                ok = 1'b1;
            end else begin
                waits++;
                if (waits > 50) break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL pix_accept: got no pix_ready within 50 cycles expected acceptance");
            pix_valid = 1'b0;
        end else begin
            sb.push_back(exp);
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
            @(negedge clk);
            check("latency_out_valid", int'(out_valid), 1);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // ---- reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_ex_ready", int'(ex_ready), 1);
        check("rst_key_level", int'(key_level), 0);
        check("rst_pix_ready", int'(pix_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);

        // ---- 1: encrypt one triple
        push(777, 123, 500);
        send_pix(8'h55, 8'h5C, w);
        send_pix(8'hAA, 8'h8D, w);
        send_pix(8'h00, 8'h79, w);
        check("t1_key_level", int'(key_level), 0);

        // ---- 2: decrypt the same triple after start
        dec = 1'b1;
        pulse_start();
        push(777, 123, 500);
        send_pix(8'h5C, 8'h55, w);
        send_pix(8'h8D, 8'hAA, w);
        send_pix(8'h79, 8'h00, w);
        // No start: the chain is still 79, so 00 ^ 11 ^ 79 = 68.
        // ---- 5: start after one byte drops the rest of that triple
        push(8'h11, 8'h22, 8'h33);
        push(8'h44, 8'h55, 8'h66);
        send_pix(8'h00, 8'h68, w);
        pulse_start();
        check("t5_key_level", int'(key_level), 1);
        send_pix(8'hA0, 8'hE4, w);
        send_pix(8'h01, 8'hF4, w);
        send_pix(8'h02, 8'h65, w);
        check("t5_key_level_end", int'(key_level), 0);

        // ---- 3: fill the FIFO
        dec = 1'b0;
        pulse_start();
        push(1, 2, 3);
        push(4, 5, 6);
        push(7, 8, 9);
        push(10, 11, 12);
        check("t3_full_level", int'(key_level), DEPTH);
        check("t3_full_ex_ready", int'(ex_ready), 0);
        push(99, 99, 99);
        check("t3_extra_ignored", int'(key_level), DEPTH);
        send_pix(8'h00, 8'h01, w);
        send_pix(8'h00, 8'h03, w);
        check("t3_ex_ready_before_pop", int'(ex_ready), 0);
        send_pix(8'h00, 8'h00, w);
        check("t3_ex_ready_after_pop", int'(ex_ready), 1);
        check("t3_level_after_pop", int'(key_level), DEPTH - 1);

        // ---- 4: backpressure
        out_ready = 1'b0;
        send_pix(8'h10, 8'h14, w);
        pix_valid = 1'b1;
        pix_data = 8'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_pix_ready_blocked", int'(pix_ready), 0);
            check("t4_out_data_stable", int'(out_data), 8'h14);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_pix(8'h20, 8'h31, w);
        send_pix(8'h30, 8'h07, w);
        check("t4_key_level", int'(key_level), 2);

        // ---- 6: reset discards, empty FIFO blocks pixels, push is not combinational
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t6_level_cleared", int'(key_level), 0);
        pix_valid = 1'b1;
        pix_data = 8'hF0;
        @(negedge clk);
        check("t6_empty_pix_ready", int'(pix_ready), 0);
        @(posedge clk);
        #1;
        ex_valid = 1'b1;
        ex1 = 23'h0F;
        ex2 = 23'h00;
        ex3 = 23'h00;
        @(negedge clk);
        check("t6_push_cycle_pix_ready", int'(pix_ready), 0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        send_pix(8'hF0, 8'hFF, w);
        check("t6_pix_ready_next_cycle", w, 0);
        out_ready = 1'b0;
        send_pix(8'h00, 8'hFF, w);
        // Asynchronous reset in the middle of a cycle with a byte pending.
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", int'(out_valid), 0);
        check("t6_rst_out_data", int'(out_data), 0);
        check("t6_rst_key_level", int'(key_level), 0);
        check("t6_rst_ex_ready", int'(ex_ready), 1);
        check("t6_rst_pix_ready", int'(pix_ready), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        push(1, 0, 0);
        send_pix(8'h00, 8'h01, w);
        tick();
        tick();
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
